// File: rtl/pwm_dac.sv
// Two-channel PWM DAC: buffers sine/cosine samples and converts them to fixed-period PWM.
// Define COMPLEMENT_EN to add dead-time-separated complementary outputs pwm_sine_n/pwm_cos_n.
module pwm_dac #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEAD  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sine_in,
    input  logic [WIDTH-1:0] cosine_in,
    input  logic             overrun_clear,
    output logic             pwm_sine,
    output logic             pwm_cos,
    output logic             period_start,
`ifdef COMPLEMENT_EN
    output logic             pwm_sine_n,
    output logic             pwm_cos_n,
`endif
    output logic             overrun
);

    localparam logic [WIDTH-1:0] CntMax = '1;
    localparam logic [WIDTH-1:0] MidDuty = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_s_q, hold_s_d, hold_c_q, hold_c_d;
    logic [WIDTH-1:0] act_s_q, act_s_d, act_c_q, act_c_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       raw_q, raw_d;
    logic             xfer;
    logic             running;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xfer    = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = StRun;
                    xfer    = pending_q;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntMax) xfer = pending_q;
                if (!enable) state_d = StStop;
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                // Finish the current period, then park without loading a new duty.
                if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        running   = (state_q != StIdle);
        hold_s_d  = sample_valid ? {~sine_in[WIDTH-1], sine_in[WIDTH-2:0]} : hold_s_q;
        hold_c_d  = sample_valid ? {~cosine_in[WIDTH-1], cosine_in[WIDTH-2:0]} : hold_c_q;
        // A strobe on a transfer cycle keeps pending set for the newly captured sample.
        pending_d = sample_valid | (pending_q & ~xfer);
        act_s_d   = xfer ? hold_s_q : act_s_q;
        act_c_d   = xfer ? hold_c_q : act_c_q;
        overrun_d = overrun_clear ? 1'b0
                                  : (overrun_q | (sample_valid & pending_q & ~xfer));
        raw_d[0]  = running && (cnt_q < act_s_q);
        raw_d[1]  = running && (cnt_q < act_c_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hold_s_q  <= MidDuty;
            hold_c_q  <= MidDuty;
            act_s_q   <= MidDuty;
            act_c_q   <= MidDuty;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            raw_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_s_q  <= hold_s_d;
            hold_c_q  <= hold_c_d;
            act_s_q   <= act_s_d;
            act_c_q   <= act_c_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            raw_q     <= raw_d;
        end
    end

    assign period_start = (state_q == StRun) && (cnt_q == '0);
    assign overrun      = overrun_q;

`ifdef COMPLEMENT_EN
    localparam int unsigned AW = $clog2(DEAD + 2);
    localparam logic [AW-1:0] DeadV = AW'(DEAD);

    logic [AW-1:0] age_q [2];
    logic [AW-1:0] age_d [2];
    logic [1:0]    main_q, main_d, comp_q, comp_d;

    // age counts cycles since the raw compare last toggled, saturating at DEAD.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (raw_d[i] != raw_q[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] == DeadV) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + 1'b1;
            end
            main_d[i] = raw_d[i] && (age_d[i] == DeadV);
            comp_d[i] = !raw_d[i] && (age_d[i] == DeadV) && (state_d != StIdle);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            age_q[0] <= DeadV;
            age_q[1] <= DeadV;
            main_q   <= '0;
            comp_q   <= '0;
        end else begin
            age_q[0] <= age_d[0];
            age_q[1] <= age_d[1];
            main_q   <= main_d;
            comp_q   <= comp_d;
        end
    end

    assign pwm_sine   = main_q[0];
    assign pwm_cos    = main_q[1];
    assign pwm_sine_n = comp_q[0];
    assign pwm_cos_n  = comp_q[1];
`else
    assign pwm_sine = raw_q[0];
    assign pwm_cos  = raw_q[1];
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Directed self-checking bench for pwm_dac: duty per period, sample buffering, overrun, stop.
module tb_pwm_dac;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       sample_valid;
    logic [9:0] sine_in;
    logic [9:0] cosine_in;
    logic       overrun_clear;
    logic       pwm_sine;
    logic       pwm_cos;
    logic       period_start;
    logic       overrun;
`ifdef COMPLEMENT_EN
    logic       pwm_sine_n;
    logic       pwm_cos_n;
`endif

    int checks = 0;
    int errors = 0;
    int hs, hc, ps, hsn, hcn, both;

    pwm_dac #(.WIDTH(10), .DEAD(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .sample_valid  (sample_valid),
        .sine_in       (sine_in),
        .cosine_in     (cosine_in),
        .overrun_clear (overrun_clear),
        .pwm_sine      (pwm_sine),
        .pwm_cos       (pwm_cos),
        .period_start  (period_start),
`ifdef COMPLEMENT_EN
        .pwm_sine_n    (pwm_sine_n),
        .pwm_cos_n     (pwm_cos_n),
`endif
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one 1024-clock window starting at the cnt=0 sample point; k is the counter value
    // during which the inputs are driven (captured on the edge ending that cycle).
    task automatic run_period(input int sv1, input logic [9:0] s1, input logic [9:0] c1,
                              input int sv2, input logic [9:0] s2, input logic [9:0] c2,
                              input int clr1, input int clr2, input int drop, input int raise,
                              output int o_hs, output int o_hc, output int o_ps,
                              output int o_hsn, output int o_hcn, output int o_both);
        o_hs = 0; o_hc = 0; o_ps = 0; o_hsn = 0; o_hcn = 0; o_both = 0;
        for (int k = 0; k < 1024; k++) begin
            o_hs += int'(pwm_sine);
            o_hc += int'(pwm_cos);
            o_ps += int'(period_start);
`ifdef COMPLEMENT_EN
            o_hsn  += int'(pwm_sine_n);
            o_hcn  += int'(pwm_cos_n);
            o_both += int'((pwm_sine & pwm_sine_n) | (pwm_cos & pwm_cos_n));
`endif
            sample_valid = (k == sv1) || (k == sv2);
            if (k == sv2) begin
                sine_in = s2; cosine_in = c2;
            end else if (k == sv1) begin
                sine_in = s1; cosine_in = c1;
            end
            overrun_clear = (k == clr1) || (k == clr2);
            if (k == drop)  enable = 1'b0;
            if (k == raise) enable = 1'b1;
            tick();
        end
        sample_valid  = 1'b0;
        overrun_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; overrun_clear = 1'b0;
        sine_in = '0; cosine_in = '0;
        tick(); tick();
        chk("rst_pwm_sine", int'(pwm_sine), 0);
        chk("rst_pwm_cos", int'(pwm_cos), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_overrun", int'(overrun), 0);

        reset = 1'b0; enable = 1'b1;
        tick();
        chk("first_period_start", int'(period_start), 1);

        // Default midscale duty
        run_period(-1, 0, 0, -1, 0, 0, -1, -1, -1, -1, hs, hc, ps, hsn, hcn, both);
        chk("p1_sine_high", hs, 512);
        chk("p1_cos_high", hc, 512);
        chk("p1_period_starts", ps, 1);

        // Mid-period sample does not disturb the running period
        run_period(300, 10'h1FF, 10'h200, -1, 0, 0, -1, -1, -1, -1, hs, hc, ps, hsn, hcn, both);
        chk("p2_sine_high", hs, 512);
        chk("p2_cos_high", hc, 512);
        chk("p2_overrun", int'(overrun), 0);

        // Two strobes in one period: overrun, second sample wins
        run_period(100, 10'h200, 10'h1FF, 600, 10'h100, 10'h300, -1, -1, -1, -1,
                   hs, hc, ps, hsn, hcn, both);
        chk("p3_sine_high", hs, 1023);
        chk("p3_cos_high", hc, 0);
        chk("p3_overrun_set", int'(overrun), 1);

        // Clear, then an overrunning strobe coincident with clear leaves overrun low
        run_period(200, 10'h000, 10'h000, 400, 10'h07F, 10'h380, 50, 400, -1, -1,
                   hs, hc, ps, hsn, hcn, both);
        chk("p4_sine_high", hs, 768);
        chk("p4_cos_high", hc, 256);
        chk("p4_overrun_clear_wins", int'(overrun), 0);

        // Strobe on the transfer cycle with a sample already pending
        run_period(500, 10'h3FF, 10'h001, 1023, 10'h1FF, 10'h1FF, -1, -1, -1, -1,
                   hs, hc, ps, hsn, hcn, both);
        chk("p5_sine_high", hs, 639);
        chk("p5_cos_high", hc, 384);
        chk("p5_no_overrun", int'(overrun), 0);

        run_period(-1, 0, 0, -1, 0, 0, -1, -1, -1, -1, hs, hc, ps, hsn, hcn, both);
        chk("p6_sine_older", hs, 511);
        chk("p6_cos_older", hc, 513);

        // Enable dropped at cnt=100 and re-raised in STOP: period completes, then IDLE
        run_period(-1, 0, 0, -1, 0, 0, -1, -1, 100, 500, hs, hc, ps, hsn, hcn, both);
        chk("p7_sine_newer", hs, 1023);
        chk("p7_cos_newer", hc, 1023);
        chk("p7_period_starts", ps, 1);
        chk("p7_no_overrun", int'(overrun), 0);
        chk("idle_pwm_sine", int'(pwm_sine), 0);
        chk("idle_pwm_cos", int'(pwm_cos), 0);
        chk("idle_period_start", int'(period_start), 0);
`ifdef COMPLEMENT_EN
        chk("idle_pwm_sine_n", int'(pwm_sine_n), 0);
        chk("idle_pwm_cos_n", int'(pwm_cos_n), 0);
`endif
        tick();
        chk("restart_period_start", int'(period_start), 1);

        // Asynchronous reset in the middle of a RUN period
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_pwm_sine", int'(pwm_sine), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm_sine", int'(pwm_sine), 0);
        chk("async_rst_pwm_cos", int'(pwm_cos), 0);
        chk("async_rst_period_start", int'(period_start), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_period_start", int'(period_start), 1);
        run_period(-1, 0, 0, -1, 0, 0, -1, -1, -1, -1, hs, hc, ps, hsn, hcn, both);
`ifdef COMPLEMENT_EN
        chk("dt_sine_high", hs, 508);
        chk("dt_cos_high", hc, 508);
        chk("dt_sine_n_high", hsn, 508);
        chk("dt_cos_n_high", hcn, 508);
        chk("dt_never_both", both, 0);
`else
        chk("p8_sine_mid", hs, 512);
        chk("p8_cos_mid", hc, 512);
`endif
        chk("p8_period_starts", ps, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
